// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter that sequences read/write accesses onto one
// single-port synchronous RAM and returns read data to the winning requester.
module ram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_a_req,
    input  logic                  i_a_we,
    input  logic [ADDR_WIDTH-1:0] i_a_addr,
    input  logic [DATA_WIDTH-1:0] i_a_wdata,
    output logic                  o_a_gnt,
    output logic [DATA_WIDTH-1:0] o_a_rdata,
    output logic                  o_a_rvalid,
    input  logic                  i_b_req,
    input  logic                  i_b_we,
    input  logic [ADDR_WIDTH-1:0] i_b_addr,
    input  logic [DATA_WIDTH-1:0] i_b_wdata,
    output logic                  o_b_gnt,
    output logic [DATA_WIDTH-1:0] o_b_rdata,
    output logic                  o_b_rvalid,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_data,
    output logic                  o_ram_we,
    input  logic [DATA_WIDTH-1:0] i_ram_data,
    output logic                  o_busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WR     = 2'd1;
    localparam logic [1:0] S_RD     = 2'd2;
    localparam logic [1:0] S_RDWAIT = 2'd3;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    logic [1:0]            state_q,    state_d;
    logic                  last_q,     last_d;
    logic                  owner_q,    owner_d;
    logic                  a_gnt_q,    a_gnt_d;
    logic                  b_gnt_q,    b_gnt_d;
    logic [DATA_WIDTH-1:0] a_rdata_q,  a_rdata_d;
    logic [DATA_WIDTH-1:0] b_rdata_q,  b_rdata_d;
    logic                  a_rvalid_q, a_rvalid_d;
    logic                  b_rvalid_q, b_rvalid_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
    logic                  ram_we_q,   ram_we_d;
    logic                  busy_q,     busy_d;
    logic                  win_b;
    logic                  win_we;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        a_gnt_d    = 1'b0;
        b_gnt_d    = 1'b0;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        ram_we_d   = 1'b0;
        win_b      = 1'b0;
        win_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_a_req || i_b_req) begin
                    // B wins when alone, or on a tie when A was served last.
                    win_b      = i_b_req && (!i_a_req || last_q == PORT_A);
                    win_we     = win_b ? i_b_we : i_a_we;
                    last_d     = win_b;
                    owner_d    = win_b;
                    a_gnt_d    = !win_b;
                    b_gnt_d    = win_b;
                    ram_addr_d = win_b ? i_b_addr  : i_a_addr;
                    ram_data_d = win_b ? i_b_wdata : i_a_wdata;
                    ram_we_d   = win_we;
                    state_d    = win_we ? S_WR : S_RD;
                end
            end
            S_WR:     state_d = S_IDLE;
            S_RD:     state_d = S_RDWAIT;
            S_RDWAIT: begin
                state_d = S_IDLE;
                if (owner_q == PORT_B) begin
                    b_rdata_d  = i_ram_data;
                    b_rvalid_d = 1'b1;
                end else begin
                    a_rdata_d  = i_ram_data;
                    a_rvalid_d = 1'b1;
                end
            end
            default:  state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: non-blocking assignments only in clocked logic, so every flop sees pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            last_q     <= PORT_B;
            owner_q    <= PORT_A;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_we_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            a_gnt_q    <= a_gnt_d;
            b_gnt_q    <= b_gnt_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_we_q   <= ram_we_d;
            busy_q     <= busy_d;
        end
    end

    assign o_a_gnt    = a_gnt_q;
    assign o_b_gnt    = b_gnt_q;
    assign o_a_rdata  = a_rdata_q;
    assign o_b_rdata  = b_rdata_q;
    assign o_a_rvalid = a_rvalid_q;
    assign o_b_rvalid = b_rvalid_q;
    assign o_ram_addr = ram_addr_q;
    assign o_ram_data = ram_data_q;
    assign o_ram_we   = ram_we_q;
    assign o_busy     = busy_q;

endmodule
